// File: rtl/half_adder_1007_pkg.sv
// Shared constants for the half_adder_1007 block: default counter width and
// the 2-bit {c,s} result encoding.
package half_adder_1007_pkg;

    localparam int unsigned DEF_CNT_W = 8;

    typedef logic [1:0] ha_res_t;

    localparam ha_res_t RES_ZERO = 2'b00;
    localparam ha_res_t RES_ONE  = 2'b01;
    localparam ha_res_t RES_TWO  = 2'b10;

endpackage

// File: rtl/half_adder_1007_if.sv
// Signal bundle between a driver of the addend bits and the half_adder_1007 block.
interface half_adder_1007_if
    import half_adder_1007_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             a;
    logic             b;
    logic             cnt_clr;
    logic             s;
    logic             c;
    logic             s_q;
    logic             c_q;
    logic             q_valid;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output a,
        output b,
        output cnt_clr,
        input  s,
        input  c,
        input  s_q,
        input  c_q,
        input  q_valid,
        input  carry_cnt
    );

    modport slave (
        input  a,
        input  b,
        input  cnt_clr,
        output s,
        output c,
        output s_q,
        output c_q,
        output q_valid,
        output carry_cnt
    );

endinterface

// File: rtl/half_adder_1007_ha_cell.sv
// Purely combinational one-bit half adder; X/Z propagate per operator semantics.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder_1007.sv
// Half adder with registered result, a valid flag and a saturating count of
// clock edges on which the carry was set.
module half_adder_1007
    import half_adder_1007_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input logic             clk,
    input logic             rst,
    half_adder_1007_if.slave bus
);

    logic             s;
    logic             c;
    logic             s_q;
    logic             c_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    ha_cell u_ha_cell (
        .a (bus.a),
        .b (bus.b),
        .s (s),
        .c (c)
    );

    // Clear wins over a simultaneous increment; the counter sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 1'b0;
            c_q     <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s_q     <= s;
            c_q     <= c;
            valid_q <= 1'b1;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.s         = s;
    assign bus.c         = c;
    assign bus.s_q       = s_q;
    assign bus.c_q       = c_q;
    assign bus.q_valid   = valid_q;
    assign bus.carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder_1007.sv
// Directed bench for half_adder_1007: a default-width instance plus a 2-bit
// counter instance for the saturation case.
module tb_half_adder_1007;
    import half_adder_1007_pkg::*;

    logic clk;
    logic rst;

    half_adder_1007_if #(.CNT_W(8)) bus ();
    half_adder_1007_if #(.CNT_W(2)) sat ();

    half_adder_1007 #(.CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    half_adder_1007 #(.CNT_W(2)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] vec_ab [4];
    logic [1:0] vec_cs [4];
    int         sat_exp [5];

    initial begin
        logic   ra;
        logic   rb;
        logic   pa;
        logic   pb;
        int     cnt_model;
        ha_res_t res_exp;

        vec_ab[0] = 2'b00; vec_cs[0] = RES_ZERO;
        vec_ab[1] = 2'b01; vec_cs[1] = RES_ONE;
        vec_ab[2] = 2'b10; vec_cs[2] = RES_ONE;
        vec_ab[3] = 2'b11; vec_cs[3] = RES_TWO;
        sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

        rst         = 1'b1;
        bus.a       = 1'b0;
        bus.b       = 1'b0;
        bus.cnt_clr = 1'b0;
        sat.a       = 1'b0;
        sat.b       = 1'b0;
        sat.cnt_clr = 1'b0;
        #1;
        check_val("rst_s_q", {31'd0, bus.s_q}, 32'd0);
        check_val("rst_c_q", {31'd0, bus.c_q}, 32'd0);
        check_val("rst_valid", {31'd0, bus.q_valid}, 32'd0);
        check_val("rst_cnt", {24'd0, bus.carry_cnt}, 32'd0);

        // Combinational sweep while reset is held: outputs must not care.
        for (int i = 0; i < 4; i++) begin
            {bus.a, bus.b} = vec_ab[i];
            #1;
            check_val("comb_cs", {30'd0, bus.c, bus.s}, {30'd0, vec_cs[i]});
            #4;
        end
        check_val("comb_rst_cnt", {24'd0, bus.carry_cnt}, 32'd0);

        @(negedge clk);
        bus.a = 1'b0;
        bus.b = 1'b0;
        rst   = 1'b0;
        #1;
        check_val("valid_before_edge", {31'd0, bus.q_valid}, 32'd0);
        tick();
        check_val("valid_after_edge", {31'd0, bus.q_valid}, 32'd1);

        // Latency: one edge from inputs to registered outputs.
        @(negedge clk);
        bus.a = 1'b1;
        bus.b = 1'b1;
        tick();
        check_val("lat_c_q_n", {31'd0, bus.c_q}, 32'd1);
        check_val("lat_s_q_n", {31'd0, bus.s_q}, 32'd0);
        @(negedge clk);
        bus.a = 1'b0;
        bus.b = 1'b1;
        tick();
        check_val("lat_s_q_n1", {31'd0, bus.s_q}, 32'd1);
        check_val("lat_c_q_n1", {31'd0, bus.c_q}, 32'd0);
        check_val("lat_cnt", {24'd0, bus.carry_cnt}, 32'd1);

        // Run the count up to 5, then reset between edges.
        @(negedge clk);
        bus.a = 1'b1;
        bus.b = 1'b1;
        repeat (4) tick();
        check_val("pre_rst_cnt", {24'd0, bus.carry_cnt}, 32'd5);
        check_val("pre_rst_c_q", {31'd0, bus.c_q}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_c_q", {31'd0, bus.c_q}, 32'd0);
        check_val("async_valid", {31'd0, bus.q_valid}, 32'd0);
        check_val("async_cnt", {24'd0, bus.carry_cnt}, 32'd0);
        check_val("async_comb_c", {31'd0, bus.c}, 32'd1);
        @(negedge clk);
        rst   = 1'b0;
        bus.a = 1'b0;
        bus.b = 1'b0;
        #1;
        check_val("rel_valid_low", {31'd0, bus.q_valid}, 32'd0);
        tick();
        check_val("rel_valid_high", {31'd0, bus.q_valid}, 32'd1);
        check_val("rel_cnt", {24'd0, bus.carry_cnt}, 32'd0);

        // Clear priority over a simultaneous increment.
        @(negedge clk);
        bus.a = 1'b1;
        bus.b = 1'b1;
        repeat (2) tick();
        check_val("clr_pre_cnt", {24'd0, bus.carry_cnt}, 32'd2);
        @(negedge clk);
        bus.cnt_clr = 1'b1;
        tick();
        check_val("clr_cnt", {24'd0, bus.carry_cnt}, 32'd0);
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        tick();
        check_val("clr_after_cnt", {24'd0, bus.carry_cnt}, 32'd1);
        @(negedge clk);
        bus.a = 1'b0;
        bus.b = 1'b0;

        // Saturation on the 2-bit instance.
        sat.a = 1'b1;
        sat.b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("sat_cnt", {30'd0, sat.carry_cnt}, sat_exp[i]);
        end
        @(negedge clk);
        sat.cnt_clr = 1'b1;
        tick();
        check_val("sat_clr", {30'd0, sat.carry_cnt}, 32'd0);
        @(negedge clk);
        sat.cnt_clr = 1'b0;
        sat.a       = 1'b0;
        sat.b       = 1'b0;

        // Random exclusivity / sum check with a saturating count model.
        bus.cnt_clr = 1'b1;
        tick();
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        cnt_model   = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ra    = 1'($urandom_range(1));
            rb    = 1'($urandom_range(1));
            bus.a = ra;
            bus.b = rb;
            #1;
            res_exp = ha_res_t'({1'b0, ra} + {1'b0, rb});
            check_val("rnd_excl", {31'd0, bus.s & bus.c}, 32'd0);
            check_val("rnd_sum", {30'd0, bus.c, bus.s}, {30'd0, res_exp});
            pa = ra;
            pb = rb;
            tick();
            check_val("rnd_q", {30'd0, bus.c_q, bus.s_q}, {30'd0, pa & pb, pa ^ pb});
            if (pa && pb && cnt_model < 255) cnt_model++;
        end
        check_val("rnd_cnt", {24'd0, bus.carry_cnt}, cnt_model);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
